// File: rtl/hazard_forwarding_unit.sv
// EX-stage operand forwarding with load-use detection, data-memory wait/timeout
// control and saturating stall statistics.

module hazard_forwarding_lane #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_src,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  exmem_wr,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_data,
  input  logic                  memwb_wr,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_data,
  input  logic [REG_ADDR_W-1:0] id_src,
  input  logic                  id_uses,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  lu_match
);
  logic exmem_hit, memwb_hit;

  // r0 is hardwired zero, so a write targeting it must never be forwarded
  assign exmem_hit = exmem_wr && (exmem_rd != '0) && (exmem_rd == ex_src);
  assign memwb_hit = memwb_wr && (memwb_rd != '0) && (memwb_rd == ex_src);

  always_comb begin
    fwd_data = rf_data;
    if (exmem_hit)      fwd_data = exmem_data;
    else if (memwb_hit) fwd_data = memwb_data;
  end

  assign lu_match = id_uses && (id_src == idex_rd);
endmodule

module hazard_forwarding_unit #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int N_OPS       = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_OPS*REG_ADDR_W-1:0]  IDEX_reg_src,
  input  logic [N_OPS*DATA_W-1:0]      reg_read_data_in,
  input  logic                         IDEX_regwrite_ctrl,
  input  logic                         IDEX_memread,
  input  logic [REG_ADDR_W-1:0]        IDEX_reg_rd,
  input  logic                         ID_valid,
  input  logic [N_OPS*REG_ADDR_W-1:0]  ID_reg_src,
  input  logic [N_OPS-1:0]             ID_uses_src,
  input  logic                         EXMEM_regwrite_ctrl,
  input  logic [REG_ADDR_W-1:0]        EXMEM_reg_rd,
  input  logic [DATA_W-1:0]            EXMEM_alu_output,
  input  logic                         EXMEM_mem_req,
  input  logic                         mem_ready,
  input  logic                         MEMWB_regwrite_ctrl,
  input  logic [REG_ADDR_W-1:0]        MEMWB_reg_rd,
  input  logic [DATA_W-1:0]            MEMWB_mux_output,
  input  logic                         stats_clr,
  output logic [N_OPS*DATA_W-1:0]      read_data,
  output logic                         pc_write_en,
  output logic                         IFID_write_en,
  output logic                         IDEX_bubble,
  output logic                         pipe_freeze,
  output logic                         mem_timeout_err,
  output logic [CNT_W-1:0]             lu_stall_cnt,
  output logic [CNT_W-1:0]             mem_wait_cnt
);
  localparam int WCTR_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCTR_W-1:0] WAIT_LAST = WCTR_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;

  logic [N_OPS-1:0][REG_ADDR_W-1:0] ex_src, id_src;
  logic [N_OPS-1:0][DATA_W-1:0]     rf_data, fwd_data;
  logic [N_OPS-1:0]                 lu_match;

  assign ex_src    = IDEX_reg_src;
  assign id_src    = ID_reg_src;
  assign rf_data   = reg_read_data_in;
  assign read_data = fwd_data;

  genvar g;
  generate
    for (g = 0; g < N_OPS; g++) begin : g_lane
      hazard_forwarding_lane #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_lane (
        .ex_src     (ex_src[g]),
        .rf_data    (rf_data[g]),
        .exmem_wr   (EXMEM_regwrite_ctrl),
        .exmem_rd   (EXMEM_reg_rd),
        .exmem_data (EXMEM_alu_output),
        .memwb_wr   (MEMWB_regwrite_ctrl),
        .memwb_rd   (MEMWB_reg_rd),
        .memwb_data (MEMWB_mux_output),
        .id_src     (id_src[g]),
        .id_uses    (ID_uses_src[g]),
        .idex_rd    (IDEX_reg_rd),
        .fwd_data   (fwd_data[g]),
        .lu_match   (lu_match[g])
      );
    end
  endgenerate

  logic lu_hit, mem_wait, freeze_c;
  state_t state, state_nxt;
  logic [WCTR_W-1:0] wait_ctr;

  assign lu_hit   = ID_valid && IDEX_memread && IDEX_regwrite_ctrl &&
                    (IDEX_reg_rd != '0) && (|lu_match);
  assign mem_wait = EXMEM_mem_req && !mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // wait_ctr counts the MEM_WAIT cycles; the RUN cycle that saw the request
  // is the extra one, hence MEM_TIMEOUT+1 wait cycles before ERROR
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_wait) state_nxt = MEM_WAIT;
      MEM_WAIT: if (!mem_wait)                   state_nxt = RUN;
                else if (wait_ctr == WAIT_LAST)  state_nxt = ERROR;
      ERROR:    state_nxt = ERROR;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    freeze_c        = mem_wait || (state == ERROR);
    mem_timeout_err = (state == ERROR);
    pipe_freeze     = rst || freeze_c;
    pc_write_en     = !rst && !(freeze_c || lu_hit);
    IFID_write_en   = !rst && !(freeze_c || lu_hit);
    IDEX_bubble     = !rst && lu_hit && !freeze_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                wait_ctr <= '0;
    else if (state != MEM_WAIT)             wait_ctr <= '0;
    else if (mem_wait && wait_ctr != '1)    wait_ctr <= wait_ctr + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_stall_cnt <= '0;
      mem_wait_cnt <= '0;
    end else if (stats_clr) begin
      lu_stall_cnt <= '0;
      mem_wait_cnt <= '0;
    end else begin
      if (IDEX_bubble && lu_stall_cnt != CNT_MAX) lu_stall_cnt <= lu_stall_cnt + 1'b1;
      if (pipe_freeze && mem_wait_cnt != CNT_MAX) mem_wait_cnt <= mem_wait_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed and randomized checks of hazard_forwarding_unit against a cycle model
// built from the forwarding / stall / timeout rules.

module tb_hazard_forwarding_unit;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MT = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0][AW-1:0] idex_src, id_src;
  logic [N-1:0][DW-1:0] rf_data;
  logic [N-1:0]         id_uses;
  logic                 idex_regwrite, idex_memread, id_valid;
  logic [AW-1:0]        idex_rd, exmem_rd, memwb_rd;
  logic                 exmem_wr, memwb_wr, exmem_mem_req, mem_ready, stats_clr;
  logic [DW-1:0]        exmem_data, memwb_data;
  logic [N-1:0][DW-1:0] read_data;
  logic                 pc_write_en, ifid_write_en, idex_bubble, pipe_freeze, mem_timeout_err;
  logic [CW-1:0]        lu_stall_cnt, mem_wait_cnt;

  int n_vec = 0;
  int n_err = 0;

  // model state: consecutive wait cycles seen, sticky error, stat counters
  int consec = 0;
  bit err    = 0;
  int lu_cnt = 0;
  int mw_cnt = 0;

  always #5 clk = ~clk;

  hazard_forwarding_unit #(
    .DATA_W(DW), .REG_ADDR_W(AW), .N_OPS(N), .MEM_TIMEOUT(MT), .CNT_W(CW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .IDEX_reg_src        (idex_src),
    .reg_read_data_in    (rf_data),
    .IDEX_regwrite_ctrl  (idex_regwrite),
    .IDEX_memread        (idex_memread),
    .IDEX_reg_rd         (idex_rd),
    .ID_valid            (id_valid),
    .ID_reg_src          (id_src),
    .ID_uses_src         (id_uses),
    .EXMEM_regwrite_ctrl (exmem_wr),
    .EXMEM_reg_rd        (exmem_rd),
    .EXMEM_alu_output    (exmem_data),
    .EXMEM_mem_req       (exmem_mem_req),
    .mem_ready           (mem_ready),
    .MEMWB_regwrite_ctrl (memwb_wr),
    .MEMWB_reg_rd        (memwb_rd),
    .MEMWB_mux_output    (memwb_data),
    .stats_clr           (stats_clr),
    .read_data           (read_data),
    .pc_write_en         (pc_write_en),
    .IFID_write_en       (ifid_write_en),
    .IDEX_bubble         (idex_bubble),
    .pipe_freeze         (pipe_freeze),
    .mem_timeout_err     (mem_timeout_err),
    .lu_stall_cnt        (lu_stall_cnt),
    .mem_wait_cnt        (mem_wait_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_fwd(input int i);
    if (exmem_wr && exmem_rd != 0 && exmem_rd == idex_src[i]) return exmem_data;
    if (memwb_wr && memwb_rd != 0 && memwb_rd == idex_src[i]) return memwb_data;
    return rf_data[i];
  endfunction

  task automatic clear_inputs();
    idex_src = '0; id_src = '0; rf_data = '0; id_uses = '0;
    idex_regwrite = 0; idex_memread = 0; id_valid = 0; idex_rd = '0;
    exmem_wr = 0; exmem_rd = '0; exmem_data = '0; exmem_mem_req = 0; mem_ready = 0;
    memwb_wr = 0; memwb_rd = '0; memwb_data = '0; stats_clr = 0;
  endtask

  // one cycle: check all outputs against the model, then advance the model at the edge
  task automatic step();
    bit lu, mw, fz, pcw, bub;
    #1;
    if (rst) begin consec = 0; err = 0; lu_cnt = 0; mw_cnt = 0; end
    lu = 0;
    for (int i = 0; i < N; i++)
      if (id_valid && idex_memread && idex_regwrite && idex_rd != 0 &&
          id_uses[i] && id_src[i] == idex_rd) lu = 1;
    mw  = exmem_mem_req && !mem_ready;
    fz  = rst || err || mw;
    pcw = !rst && !(fz || lu);
    bub = !rst && lu && !(err || mw);
    for (int i = 0; i < N; i++) chk($sformatf("read_data[%0d]", i), 64'(read_data[i]), 64'(ref_fwd(i)));
    chk("pc_write_en", 64'(pc_write_en), 64'(pcw));
    chk("IFID_write_en", 64'(ifid_write_en), 64'(pcw));
    chk("IDEX_bubble", 64'(idex_bubble), 64'(bub));
    chk("pipe_freeze", 64'(pipe_freeze), 64'(fz));
    chk("mem_timeout_err", 64'(mem_timeout_err), 64'(err));
    chk("lu_stall_cnt", 64'(lu_stall_cnt), 64'(lu_cnt));
    chk("mem_wait_cnt", 64'(mem_wait_cnt), 64'(mw_cnt));
    @(posedge clk);
    if (!rst) begin
      if (stats_clr) begin lu_cnt = 0; mw_cnt = 0; end
      else begin
        if (bub && lu_cnt < CMAX) lu_cnt++;
        if (fz && mw_cnt < CMAX) mw_cnt++;
      end
      if (!err) begin
        consec = mw ? consec + 1 : 0;
        if (consec == MT + 1) err = 1;
      end
    end
    #1;
  endtask

  task automatic set_load_use(input bit hit);
    id_valid = 1; idex_memread = hit; idex_regwrite = 1; idex_rd = 5'd8;
    id_src[0] = 5'd8; id_uses = 3'b001;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step(); step();
    chk("reset pipe_freeze", 64'(pipe_freeze), 64'd1);
    rst = 0;

    // EX/MEM beats MEM/WB on the same register; otherwise MEM/WB forwards
    exmem_wr = 1; exmem_rd = 5; exmem_data = 32'h1111;
    memwb_wr = 1; memwb_rd = 5; memwb_data = 32'h2222;
    idex_src[0] = 5; rf_data[0] = 32'h0BAD;
    step(); chk("ex_prio", 64'(read_data[0]), 64'h1111);
    exmem_rd = 6;
    step(); chk("mem_fwd", 64'(read_data[0]), 64'h2222);

    // r0 never forwarded; only operand 2 matches MEM/WB
    exmem_rd = 0; memwb_rd = 0; idex_src[0] = 0; rf_data[0] = 32'hABCD;
    step(); chk("r0_nofwd", 64'(read_data[0]), 64'hABCD);
    idex_src = {5'd9, 5'd2, 5'd1}; rf_data = {32'hC0, 32'hB0, 32'hA0};
    exmem_rd = 3; memwb_rd = 9; memwb_data = 32'h9999;
    step();
    chk("op2_fwd", 64'(read_data[2]), 64'h9999);
    chk("op1_rf", 64'(read_data[1]), 64'hB0);
    chk("op0_rf", 64'(read_data[0]), 64'hA0);

    // load-use: one stall cycle, then free-running
    clear_inputs();
    set_load_use(1);
    step(); chk("lu_bubble", 64'(idex_bubble), 64'd1);
    idex_memread = 0;
    step(); chk("lu_release", 64'(pc_write_en), 64'd1);
    chk("lu_cnt_1", 64'(lu_stall_cnt), 64'd1);
    set_load_use(1); id_uses = '0;
    step(); chk("uses0_nostall", 64'(pc_write_en), 64'd1);

    // memory wait overlapping a load-use: freeze 2 cycles, no bubble while frozen
    clear_inputs(); stats_clr = 1; step(); stats_clr = 0;
    set_load_use(1); exmem_mem_req = 1; mem_ready = 0;
    step(); chk("mw_fz1", 64'(pipe_freeze), 64'd1);
    step(); chk("mw_bub2", 64'(idex_bubble), 64'd0);
    mem_ready = 1;
    step(); chk("mw_cnt_2", 64'(mem_wait_cnt), 64'd2);

    // timeout: 5 wait cycles, then sticky error until rst
    clear_inputs(); exmem_mem_req = 1;
    for (int k = 0; k < MT + 1; k++) step();
    chk("timeout_err", 64'(mem_timeout_err), 64'd1);
    mem_ready = 1;
    step(); step(); chk("err_sticky", 64'(mem_timeout_err), 64'd1);
    rst = 1; step(); rst = 0; clear_inputs();
    step(); chk("err_cleared", 64'(mem_timeout_err), 64'd0);

    // counter saturation and clear-over-increment
    for (int k = 0; k < 5; k++) begin
      set_load_use(1); step();
      clear_inputs(); step();
    end
    chk("lu_sat", 64'(lu_stall_cnt), 64'(CMAX));
    set_load_use(1); stats_clr = 1;
    step(); chk("clr_over_inc", 64'(lu_stall_cnt), 64'd0);
    clear_inputs();

    // randomized traffic with small register range to provoke hits
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) < 3);
      for (int i = 0; i < N; i++) begin
        idex_src[i] = AW'($urandom_range(0, 7));
        id_src[i]   = AW'($urandom_range(0, 7));
        rf_data[i]  = $urandom;
      end
      id_uses       = N'($urandom);
      idex_regwrite = 1'($urandom); idex_memread = 1'($urandom);
      id_valid      = 1'($urandom); idex_rd = AW'($urandom_range(0, 7));
      exmem_wr      = 1'($urandom); exmem_rd = AW'($urandom_range(0, 7)); exmem_data = $urandom;
      memwb_wr      = 1'($urandom); memwb_rd = AW'($urandom_range(0, 7)); memwb_data = $urandom;
      exmem_mem_req = ($urandom_range(0, 99) < 40);
      mem_ready     = ($urandom_range(0, 99) < 50);
      stats_clr     = ($urandom_range(0, 99) < 10);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_forwarding_unit.md
# hazard_forwarding_unit

Parametrised successor to the EX-stage forwarding unit. It combines N-operand data forwarding from EX/MEM and MEM/WB with load-use hazard detection and a data-memory wait/timeout state machine. It also keeps saturating stall statistics. It sits between the ID/EX register outputs and the ALU operand inputs, and drives the PC, IF/ID and ID/EX write/bubble controls.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_ADDR_W, 5, register specifier width
- N_OPS, 2, number of source operands forwarded (≥1)
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before error (≥1)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock (rising edge); one clock domain
- rst  in  1  asynchronous, active-high reset
- IDEX_reg_src  in  N_OPS*REG_ADDR_W  EX-stage source specifiers; operand i at slice i
- reg_read_data_in  in  N_OPS*DATA_W  EX-stage register-file operands
- IDEX_regwrite_ctrl, IDEX_memread  in  1 each  EX-stage instruction control
- IDEX_reg_rd  in  REG_ADDR_W  EX-stage destination
- ID_valid  in  1  ID stage holds a real instruction
- ID_reg_src  in  N_OPS*REG_ADDR_W  ID-stage source specifiers
- ID_uses_src  in  N_OPS  per-operand "actually read" flags
- EXMEM_regwrite_ctrl  in  1;  EXMEM_reg_rd  in  REG_ADDR_W;  EXMEM_alu_output  in  DATA_W
- EXMEM_mem_req  in  1  MEM stage issuing a load/store;  mem_ready  in  1  memory completes this cycle
- MEMWB_regwrite_ctrl  in  1;  MEMWB_reg_rd  in  REG_ADDR_W;  MEMWB_mux_output  in  DATA_W
- stats_clr  in  1  synchronous clear of counters
- read_data  out  N_OPS*DATA_W  forwarded operands
- pc_write_en, IFID_write_en  out  1  front-end advance enables
- IDEX_bubble  out  1  zero ID/EX control fields this cycle
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- mem_timeout_err  out  1  sticky error
- lu_stall_cnt, mem_wait_cnt  out  CNT_W each  statistics

## Operation
- Forwarding, per operand i, is combinational with this priority:
  - EX/MEM match: EXMEM_regwrite_ctrl & EXMEM_reg_rd≠0 & EXMEM_reg_rd==src_i → EXMEM_alu_output.
  - Else MEM/WB match: MEMWB_regwrite_ctrl & MEMWB_reg_rd≠0 & MEMWB_reg_rd==src_i → MEMWB_mux_output.
  - Else reg_read_data_in slice i.
  - MEM/WB forwarding is suppressed only when EX/MEM matches the same operand. An unrelated EX/MEM write never blocks it.
  - Register 0 is never forwarded.
- Load-use: lu_hit = ID_valid & IDEX_memread & IDEX_regwrite_ctrl & IDEX_reg_rd≠0 & OR_i(ID_uses_src[i] & ID_reg_src_i==IDEX_reg_rd).
- Memory wait: mem_wait = EXMEM_mem_req & !mem_ready.
- FSM states:
  - RUN: mem_wait → MEM_WAIT.
  - MEM_WAIT: !mem_wait → RUN. wait_ctr reaches MEM_TIMEOUT with mem_wait still high → ERROR.
  - ERROR: terminal until rst.
- wait_ctr: zeroed in RUN; increments each MEM_WAIT cycle with mem_wait high; width ceil(log2(MEM_TIMEOUT+1)).
- Control outputs (combinational from state and inputs):
  - freeze_c = mem_wait | (state==ERROR).
  - pipe_freeze = freeze_c.
  - pc_write_en = IFID_write_en = !(freeze_c | lu_hit).
  - IDEX_bubble = lu_hit & !freeze_c. Freeze dominates: no bubble is inserted while frozen.
- mem_timeout_err = (state==ERROR).
- Counters:
  - lu_stall_cnt +1 per cycle with IDEX_bubble.
  - mem_wait_cnt +1 per cycle with pipe_freeze.
  - Both saturate at 2^CNT_W−1.
  - stats_clr zeroes both and overrides an increment in the same cycle.

## Timing
- Reset (async assert, sync-released by the system):
  - state=RUN, wait_ctr=0, counters=0, mem_timeout_err=0.
  - While rst is high: pc_write_en=0, IFID_write_en=0, IDEX_bubble=0, pipe_freeze=1.
  - read_data stays combinational.
- Forwarding and control outputs have zero-cycle latency. State, counters and error update on the rising clk edge.
- Memory wait: freeze asserts in the same cycle mem_wait rises, while still in RUN. It releases in the same cycle mem_ready is seen.
- Timeout: error after MEM_TIMEOUT+1 consecutive wait cycles.
  - With MEM_TIMEOUT=1: wait cycles 1 and 2 freeze; the edge ending cycle 2 enters ERROR.
- A load-use stall lasts exactly 1 cycle, since the load moves to EX/MEM and lu_hit drops. It lasts longer if it overlaps a freeze.
- rst mid-wait: immediate return to RUN; error and counters cleared.

## Test plan
- EX/MEM and MEM/WB both write r5; operand0 src=5, EXMEM=0x1111, MEMWB=0x2222 → read_data[0]=0x1111. EX/MEM writes r6 instead → 0x2222 (a plain MEM-hazard forward).
- rd=0 on both stages with src=0, regfile value 0xABCD → 0xABCD; N_OPS=3 with operand 2 matching MEM/WB only → only slice 2 forwarded.
- Load to r8 in EX, ID reads r8 (uses=1) → one cycle of pc_write_en=0, IDEX_bubble=1, then free-running; lu_stall_cnt=1. uses=0 → no stall.
- mem_req held 3 cycles with mem_ready on the 3rd, simultaneous with lu_hit → pipe_freeze high for 2 cycles, IDEX_bubble=0 during freeze; mem_wait_cnt=2.
- MEM_TIMEOUT=4, mem_ready never asserted → ERROR after 5 wait cycles; mem_timeout_err stays 1 with mem_ready later high; rst clears to 0.
- CNT_W=2: 5 load-use stalls → lu_stall_cnt=3. stats_clr during an increment cycle → 0.
